// File: rtl/fft_output_unload.sv
// Captures one 32-word fft result frame (4 words/beat), optionally un-bit-reverses it, and
// streams it out one word per cycle under valid/ready; beats arriving while draining are dropped and flagged.
module fft_output_unload #(
   parameter int WORDSIZE = 16,
   parameter int ADDRSIZE = 3,
   parameter int REORDER  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORDSIZE-1:0]   in0,
   input  logic [WORDSIZE-1:0]   in1,
   input  logic [WORDSIZE-1:0]   in2,
   input  logic [WORDSIZE-1:0]   in3,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORDSIZE-1:0]   out_data,
   output logic [ADDRSIZE+1:0]   out_index,
   output logic                  out_last,
   output logic                  frame_done,
   output logic                  overrun
);
   localparam int NWORDS = 4 << ADDRSIZE;
   localparam int IW     = ADDRSIZE + 2;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CAPTURE = 2'd1;
   localparam logic [1:0] DRAIN   = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [ADDRSIZE-1:0]   beat_q, beat_d;
   logic [IW-1:0]         rd_q, rd_d;
   logic                  frame_done_q, frame_done_d;
   logic                  overrun_q, overrun_d;
   logic [WORDSIZE-1:0]   mem_q [NWORDS];
   logic [WORDSIZE-1:0]   mem_d [NWORDS];

   logic                  draining;
   logic                  accept;
   logic [IW-1:0]         rd_rev;
   logic [IW-1:0]         rd_addr;
   logic [IW-1:0]         wr_base;

   // in_ready is gated by rst so it reads 0 during reset even though the state is IDLE
   assign draining = (state_q == DRAIN);
   assign in_ready = ~rst & ~draining;
   assign accept   = in_valid & in_ready;
   assign wr_base  = {beat_q, 2'b00};

   always_comb begin
      rd_rev = '0;
      for (int i = 0; i < IW; i++) begin
         rd_rev[i] = rd_q[IW-1-i];
      end
   end

   assign rd_addr    = (REORDER != 0) ? rd_rev : rd_q;
   assign out_valid  = draining;
   assign out_data   = draining ? mem_q[rd_addr] : '0;
   assign out_index  = draining ? rd_q : '0;
   assign out_last   = draining & (&rd_q);
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;

   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      rd_d         = rd_q;
      frame_done_d = 1'b0;
      overrun_d    = overrun_q | (in_valid & ~in_ready);
      mem_d        = mem_q;
      if (accept) begin
         mem_d[wr_base + IW'(0)] = in0;
         mem_d[wr_base + IW'(1)] = in1;
         mem_d[wr_base + IW'(2)] = in2;
         mem_d[wr_base + IW'(3)] = in3;
      end
      case (state_q)
         IDLE: begin
            if (accept) begin
               beat_d  = ADDRSIZE'(1);
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            if (accept) begin
               beat_d = beat_q + ADDRSIZE'(1);
               if (&beat_q) begin
                  state_d = DRAIN;
                  rd_d    = '0;
               end
            end
         end
         DRAIN: begin
            if (out_ready) begin
               rd_d = rd_q + IW'(1);
               if (&rd_q) begin
                  state_d      = IDLE;
                  frame_done_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         beat_q       <= '0;
         rd_q         <= '0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         rd_q         <= rd_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
      end
   end

   // Buffer contents are don't-care after reset, so no reset branch here
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule
